// File: rtl/divu_seq_if.sv
// divu_seq_if: request/result bundle for the sequential divider.
// The Signed request field exists only when DIVU_SEQ_SIGNED_DIV_EN is defined.
interface divu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
`ifdef DIVU_SEQ_SIGNED_DIV_EN
    logic             Signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivZero;

    // Requester side (pipeline / bench)
    modport master (
`ifdef DIVU_SEQ_SIGNED_DIV_EN
        output Signed,
`endif
        output start, Dividend, Divisor,
        input  busy, done, Quotient, Remainder, DivZero
    );

    // Divider side
    modport slave (
`ifdef DIVU_SEQ_SIGNED_DIV_EN
        input  Signed,
`endif
        input  start, Dividend, Divisor,
        output busy, done, Quotient, Remainder, DivZero
    );
endinterface

// File: rtl/divu_seq.sv
// divu_seq: multi-cycle restoring divider, one quotient bit per clock.
// Optional macro DIVU_SEQ_SIGNED_DIV_EN adds two's-complement operation
// (magnitude divide plus sign fix-up on the way out).
//
// state  | meaning
// IDLE   | waiting for start, results held
// RUN    | shift/subtract iterations, count WIDTH-1 down to 0
// FINISH | done pulse, results valid; a new start may be accepted here
module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    divu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;     // holds remaining dividend bits, fills with quotient bits
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dz_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef DIVU_SEQ_SIGNED_DIV_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    // Magnitudes at capture; MIN stays MIN, which as an unsigned magnitude is correct
    always_comb begin
        a_neg = bus.Signed & bus.Dividend[WIDTH-1];
        b_neg = bus.Signed & bus.Divisor[WIDTH-1];
        a_mag = a_neg ? (~bus.Dividend + 1'b1) : bus.Dividend;
        b_mag = b_neg ? (~bus.Divisor + 1'b1) : bus.Divisor;
    end
`else
    assign a_mag = bus.Dividend;
    assign b_mag = bus.Divisor;
`endif

    // One restoring step: shift in next dividend bit, trial-subtract at WIDTH+1 bits
    always_comb begin
        shifted           = {rem, quo[WIDTH-1]};
        {borrow, trial}   = {1'b0, shifted} - {2'b00, dvsr};
        rem_next          = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next          = {quo[WIDTH-2:0], ~borrow};
    end

`ifdef DIVU_SEQ_SIGNED_DIV_EN
    // Sign fix-up of the final step: quotient by sign mismatch, remainder follows dividend
    always_comb begin
        fin_q = neg_q ? (~quo_next + 1'b1) : quo_next;
        fin_r = neg_r ? (~rem_next + 1'b1) : rem_next;
    end
`else
    assign fin_q = quo_next;
    assign fin_r = rem_next;
`endif

    // Control FSM, datapath registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= 1'b0;
`ifdef DIVU_SEQ_SIGNED_DIV_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (bus.start) begin
                        if (bus.Divisor == '0) begin
                            // Zero divisor skips RUN; results are ready for the FINISH cycle
                            state  <= FINISH;
                            q_reg  <= '1;
                            r_reg  <= bus.Dividend;
                            dz_reg <= 1'b1;
                        end else begin
                            state <= RUN;
                            count <= CW'(WIDTH - 1);
                            rem   <= '0;
                            quo   <= a_mag;
                            dvsr  <= b_mag;
`ifdef DIVU_SEQ_SIGNED_DIV_EN
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state  <= FINISH;
                        q_reg  <= fin_q;
                        r_reg  <= fin_r;
                        dz_reg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == FINISH);
    assign bus.Quotient  = q_reg;
    assign bus.Remainder = r_reg;
    assign bus.DivZero   = dz_reg;
endmodule
